// File: rtl/crank_wheel_gen.sv
// ---------------------------------------------------------------------------
// crank_wheel_gen
//
// Crank/cam trigger-wheel generator for an N-minus-M wheel. A prescaler
// divides clk into subticks, a sub counter splits every tooth slot into
// 2^SUB_W subticks (MISSING+1 times as many for the gap slot), and the
// prescaler top is stepped by a signed amount at every slot end. This gives
// an accelerating or decelerating wheel. A cam signal is active on every
// second revolution.
//
// Optional feature macro: CRANK_WHEEL_GEN_CAM_EN
//   defined   : cam window logic is built; cam_out is high while
//               cycle_phase==1 and CAM_RISE <= tooth_idx < CAM_FALL.
//   undefined : cam_out is tied to 0 (cycle_phase and rev_pulse remain).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           run enable; all state freezes while low
//   load         one-clk strobe: pre_top<-pre_init, tooth 0 / sub 0, pre_cnt 0
//   pre_init     prescaler top loaded by load
//   pre_step     signed per-tooth change of pre_top (PRE_W+1 bits)
//   pre_min      lower saturation bound of pre_top (wins over pre_max)
//   pre_max      upper saturation bound of pre_top
//   vr_out       tooth signal: low in the first half of a slot, high in the second
//   cam_out      cam signal
//   tooth_idx    current tooth, 0..TEETH-MISSING-1
//   rev_pulse    one-clk pulse when the wheel wraps to tooth 0
//   cycle_phase  revolution parity within 720 degrees
//   pre_top_out  current prescaler top
// ---------------------------------------------------------------------------
module crank_wheel_gen #(
    parameter int TEETH    = 60,
    parameter int MISSING  = 2,
    parameter int SUB_W    = 6,
    parameter int PRE_W    = 16,
    parameter int PRE_RST  = 3,
    parameter int CAM_RISE = 4,
    parameter int CAM_FALL = 54
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [PRE_W-1:0]         pre_init,
    input  logic [PRE_W:0]           pre_step,
    input  logic [PRE_W-1:0]         pre_min,
    input  logic [PRE_W-1:0]         pre_max,
    output logic                     vr_out,
    output logic                     cam_out,
    output logic [$clog2(TEETH)-1:0] tooth_idx,
    output logic                     rev_pulse,
    output logic                     cycle_phase,
    output logic [PRE_W-1:0]         pre_top_out
);

    localparam int TI_W = $clog2(TEETH);
    localparam int SC_W = SUB_W + $clog2(MISSING + 1);

    localparam logic [TI_W-1:0]  GAP_IDX   = TI_W'(TEETH - MISSING - 1);
    localparam logic [SC_W-1:0]  SUB_TOP_N = SC_W'((1 << SUB_W) - 1);
    localparam logic [SC_W-1:0]  SUB_TOP_G = SC_W'((MISSING + 1) * (1 << SUB_W) - 1);
    localparam logic [PRE_W-1:0] PRE_RST_V = PRE_W'(PRE_RST);

    // Elaboration-time guard against an impossible wheel or cam window
    generate
        if (MISSING < 1 || MISSING > TEETH - 2 || CAM_RISE >= CAM_FALL ||
            CAM_FALL > TEETH - MISSING - 1) begin : g_bad_params
            $error("crank_wheel_gen: illegal wheel/cam parameters");
        end
    endgenerate

    // Next pre_top: signed sum in PRE_W+2 bits, clamp to max first and then to min,
    // so that pre_min wins when the bounds cross.
    function automatic logic [PRE_W-1:0] sat_step(
        input logic [PRE_W-1:0] top,
        input logic [PRE_W:0]   step,
        input logic [PRE_W-1:0] lo,
        input logic [PRE_W-1:0] hi
    );
        logic signed [PRE_W+1:0] sum;
        logic signed [PRE_W+1:0] lo_s;
        logic signed [PRE_W+1:0] hi_s;
        logic signed [PRE_W+1:0] res;
        sum  = $signed({2'b00, top}) + $signed({step[PRE_W], step});
        lo_s = $signed({2'b00, lo});
        hi_s = $signed({2'b00, hi});
        if (sum > hi_s) begin
            res = hi_s;
        end else begin
            res = sum;
        end
        if (res < lo_s) begin
            res = lo_s;
        end else begin
            res = res;
        end
        return res[PRE_W-1:0];
    endfunction

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [SC_W-1:0]  sub_q,     sub_d;
    logic [TI_W-1:0]  tooth_q,   tooth_d;
    logic [PRE_W-1:0] pre_top_q, pre_top_d;
    logic             phase_q,   phase_d;
    logic             vr_q,      vr_d;
    logic             rev_q,     rev_d;

    logic             gap_s;
    logic [SC_W-1:0]  sub_top_s;
    logic             subtick_s;

    assign gap_s     = (tooth_q == GAP_IDX);
    assign sub_top_s = gap_s ? SUB_TOP_G : SUB_TOP_N;
    assign subtick_s = (pre_cnt_q == pre_top_q);

    // Next-state logic for prescaler, slot position, speed ramp and revolution flags
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        sub_d     = sub_q;
        tooth_d   = tooth_q;
        pre_top_d = pre_top_q;
        phase_d   = phase_q;
        vr_d      = vr_q;
        rev_d     = 1'b0;

        // vr follows the registered sub counter, one clk behind it
        if (en) begin
            vr_d = (sub_q > (sub_top_s >> 1));
        end else begin
            vr_d = vr_q;
        end

        if (load) begin
            // load overrides a coincident slot end: no step, no wrap pulse
            pre_top_d = pre_init;
            pre_cnt_d = {PRE_W{1'b0}};
            sub_d     = {SC_W{1'b0}};
            tooth_d   = {TI_W{1'b0}};
        end else if (en) begin
            if (subtick_s) begin
                pre_cnt_d = {PRE_W{1'b0}};
                if (sub_q == sub_top_s) begin
                    sub_d     = {SC_W{1'b0}};
                    pre_top_d = sat_step(pre_top_q, pre_step, pre_min, pre_max);
                    if (gap_s) begin
                        tooth_d = {TI_W{1'b0}};
                        phase_d = ~phase_q;
                        rev_d   = 1'b1;
                    end else begin
                        tooth_d = tooth_q + TI_W'(1);
                    end
                end else begin
                    sub_d = sub_q + SC_W'(1);
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
        end else begin
            pre_cnt_d = pre_cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= {PRE_W{1'b0}};
            sub_q     <= {SC_W{1'b0}};
            tooth_q   <= {TI_W{1'b0}};
            pre_top_q <= PRE_RST_V;
            phase_q   <= 1'b0;
            vr_q      <= 1'b0;
            rev_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            sub_q     <= sub_d;
            tooth_q   <= tooth_d;
            pre_top_q <= pre_top_d;
            phase_q   <= phase_d;
            vr_q      <= vr_d;
            rev_q     <= rev_d;
        end
    end

`ifdef CRANK_WHEEL_GEN_CAM_EN
    localparam logic [TI_W-1:0] RISE_IDX = TI_W'(CAM_RISE);
    localparam logic [TI_W-1:0] FALL_IDX = TI_W'(CAM_FALL);

    logic cam_q, cam_d;

    // Cam window evaluated on the next position so cam_out moves together with tooth_idx
    always_comb begin
        cam_d = phase_d && (tooth_d >= RISE_IDX) && (tooth_d < FALL_IDX);
    end

    // Cam output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_q <= 1'b0;
        end else begin
            cam_q <= cam_d;
        end
    end

    assign cam_out = cam_q;
`else
    assign cam_out = 1'b0;
`endif

    assign vr_out      = vr_q;
    assign tooth_idx   = tooth_q;
    assign rev_pulse   = rev_q;
    assign cycle_phase = phase_q;
    assign pre_top_out = pre_top_q;

endmodule

// File: doc/crank_wheel_gen.md
# crank_wheel_gen

Synthesizable crank/cam trigger-wheel generator. It produces a VR-style tooth signal for an N-minus-M wheel with a variable tooth period (accelerating or decelerating), a missing-tooth gap, and a 720° cam signal. It drives the angle-generator capture input in simulation and in on-board loopback. It replaces the hand-written tooth/prescaler stimulus loops with one parametrised, reusable block.

## Interface
Parameters:
- TEETH, 60: tooth positions per revolution, including missing teeth.
- MISSING, 2: missing teeth; must satisfy 1..TEETH-2.
- SUB_W, 6: log2 of the number of subticks per tooth (64).
- PRE_W, 16: prescaler width.
- PRE_RST, 3: value of pre_top after reset.
- CAM_RISE, 4: tooth index at which cam rises on the cam-active revolution.
- CAM_FALL, 54: tooth index at which cam falls; must satisfy CAM_RISE < CAM_FALL ≤ TEETH-MISSING-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  run enable; when low, all state freezes.
- load  in  1  one-clk strobe: pre_top←pre_init, position←tooth 0 / sub 0, pre_cnt←0.
- pre_init  in  PRE_W  prescaler top loaded by load.
- pre_step  in  PRE_W+1  signed per-tooth change of pre_top.
- pre_min  in  PRE_W  lower saturation bound for pre_top.
- pre_max  in  PRE_W  upper saturation bound for pre_top.
- vr_out  out  1  tooth signal.
- cam_out  out  1  cam signal.
- tooth_idx  out  clog2(TEETH)  current tooth, 0..TEETH-MISSING-1.
- rev_pulse  out  1  one-clk pulse at revolution wrap.
- cycle_phase  out  1  revolution parity (0/1 within 720°).
- pre_top_out  out  PRE_W  current prescaler top.

## Operation
- Prescaler: pre_cnt counts 0..pre_top. A subtick occurs in the clk where pre_cnt==pre_top; pre_cnt then wraps to 0.
- Sub counter: SUB_W+clog2(MISSING+1) bits, advanced on each subtick.
  - sub_top is 2^SUB_W-1 for normal teeth.
  - sub_top is (MISSING+1)·2^SUB_W-1 for tooth TEETH-MISSING-1 (the gap slot).
- Slot end: a subtick with sub==sub_top. At slot end:
  - sub←0.
  - tooth_idx increments, or wraps to 0 after the gap slot.
  - pre_top←sat(pre_top+pre_step, pre_min, pre_max). The sum is computed in PRE_W+2 signed bits. If pre_min>pre_max, pre_min wins.
- vr_out is registered and equals (sub > sub_top>>1). It is low for the first half of each slot and high for the second half; this also applies to the gap slot.
- On wrap to tooth 0: rev_pulse=1 for one clk, and cycle_phase toggles.
- cam_out=1 iff cycle_phase==1 and CAM_RISE ≤ tooth_idx < CAM_FALL. It is registered and changes at slot boundaries only.
- Priority: rst > load > en. load is honoured even when en=0. If load coincides with a slot end, load wins: no step is applied and no rev_pulse is generated.
- en=0: pre_cnt, sub, tooth_idx, pre_top and all outputs hold; a pending rev_pulse is not repeated.

## Timing
- Reset values, asserted asynchronously:
  - vr_out=0, cam_out=0, rev_pulse=0.
  - tooth_idx=0, cycle_phase=0.
  - pre_cnt=0, sub=0, pre_top=PRE_RST.
- Subtick period is pre_top+1 clk. A normal slot lasts 2^SUB_W·(pre_top+1) clk; the gap slot lasts (MISSING+1) times that.
- A new pre_top takes effect from the first clk of the next slot.
- Output latency: vr_out lags sub by 1 clk. tooth_idx, rev_pulse and cam_out update in the clk after the slot-end subtick.
- After load, the first subtick occurs pre_init+1 clk later.
- Reset mid-operation (including mid-gap) clears all state immediately; counting resumes from tooth 0 on the first clk with rst=0 and en=1.

## Configuration
- CRANK_WHEEL_GEN_CAM_EN defined: the cycle_phase, CAM_RISE and CAM_FALL logic is built, and cam_out behaves as specified above.
- CRANK_WHEEL_GEN_CAM_EN undefined: the cam comparison logic is removed and cam_out is tied to 0. cycle_phase and rev_pulse remain.

## Test plan
All scenarios use defaults unless stated.
- Steady speed: reset, en=1, pre_step=0 → tooth 0 has vr_out low for 128 clk then high for 128 clk; rev_pulse spacing is 15360 clk; tooth_idx runs 0..57.
- Gap slot: tooth 57 lasts 768 clk, with vr_out low 384 clk then high 384 clk; then tooth_idx returns to 0 with rev_pulse=1 for one clk.
- Acceleration and saturation: load pre_init=3, pre_step=+1, pre_min=0, pre_max=5 → successive tooth lengths are 256, 320, 384, 384, … clk; pre_top_out holds at 5.
- Cam: on the cycle_phase=1 revolution, cam_out rises 1 clk after the tooth-4 boundary and falls 1 clk after the tooth-54 boundary; on the cycle_phase=0 revolution, cam_out stays 0. Rebuild without CRANK_WHEEL_GEN_CAM_EN → cam_out constant 0.
- Control: en=0 for 1000 clk mid-tooth → all outputs hold and the remaining tooth time resumes unchanged. load coincident with a slot end → pre_top=pre_init, tooth_idx=0, no rev_pulse.
- Async reset asserted mid-gap → all outputs drop to their reset values in the same timestep, before any clk edge.
